serial_chunk_adder: RTL and testbench
=====================================

// Module: serial_chunk_adder
// PURPOSE
//  Parametrised multi-cycle adder: S = A + B + CIN on WIDTH-bit operands, computed CHUNK bits
//  per clock through one CHUNK-bit adder and a registered carry.
//  Successor to the 4-bit combinational ripple adder; trades latency for area in wide datapaths.
//  Sits between a valid/ready producer and consumer, and carries signed-overflow reporting.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits; must be a multiple of CHUNK
//  CHUNK   4   bits added per cycle; NCH = WIDTH/CHUNK cycles per operation (CHUNK==WIDTH is legal)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands a/b/cin valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts the result
//  sum        out  WIDTH  A+B+cin, modulo 2^WIDTH
//  cout       out  1      unsigned carry out of the MSB
//  ovf        out  1      signed overflow: a[MSB]==b[MSB] && sum[MSB]!=a[MSB]
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
//   - Chunk counter and carry register cleared.
//  FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from state.
//  IDLE
//   - in_ready=1, out_valid=0.
//   - On an edge with in_valid=1: latch a, b, cin into operand registers; carry register = cin; idx=0; go to RUN.
//  RUN
//   - in_ready=0. Each cycle, add chunk idx of both operands plus the carry register.
//   - The result is written to sum[idx*CHUNK +: CHUNK]; the carry register takes the chunk carry-out; idx increments.
//   - On idx==NCH-1: cout = final carry; ovf computed from latched a/b MSBs and new sum MSB; go to DONE.
//  DONE
//   - out_valid=1, in_ready=0. sum, cout and ovf are held stable.
//   - On an edge with out_ready=1: go to IDLE, out_valid=0 (sum/cout/ovf keep their values).
//  Latency
//   - Input accepted at edge t; out_valid=1 after edge t+NCH.
//   - Minimum issue interval is NCH+2 cycles (RUN x NCH, DONE >=1, IDLE 1).
//  Boundaries
//   - a, b, cin changing after acceptance are ignored; the latched copies are used.
//   - in_valid asserted during RUN or DONE is ignored; no acceptance.
//   - out_ready asserted outside DONE has no effect.
//   - sum is partial during RUN. Only sample sum/cout/ovf while out_valid=1.
//   - Carry ripples across all chunk boundaries, e.g. 0xFFFF+1 gives 0x0000 with cout=1.
//   - Reset asserted mid-RUN or in DONE aborts the operation: reset values immediately, result discarded.
//   - NCH==1: RUN lasts one cycle; the counter is degenerate (width >=1 bit).
// TESTING (WIDTH=16, CHUNK=4 unless stated)
//  1 a=0x0002, b=0x0005, cin=0 -> after 4 RUN cycles out_valid=1, sum=0x0007, cout=0, ovf=0.
//  2 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (full carry ripple).
//  3 a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
//  4 hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b
//      -> out_valid, sum stay stable; in_ready=0; no new op starts.
//    Then out_ready=1 -> IDLE, in_ready=1 next cycle.
//  5 rst_n=0 during RUN idx=2 -> out_valid=0, in_ready=1 without a clock edge.
//    After release, a=0x1234, b=0x1111 -> sum=0x2345.
//  6 WIDTH=CHUNK=4: a=10, b=5, cin=1 -> sum=0, cout=1, ovf=0, out_valid one edge after acceptance.

Source files
------------

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: S = A + B + CIN, CHUNK bits per clock through one CHUNK-bit adder
// with a registered carry, wrapped in a valid/ready handshake with signed-overflow flag.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for operands, in_ready=1
//  RUN   | adding chunk idx each cycle, carry held in carry_q
//  DONE  | result stable, out_valid=1 until out_ready
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH   = WIDTH / CHUNK;
    // Counter keeps at least one bit so the single-chunk case still elaborates cleanly.
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    int               chunk_lsb;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_carry;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state so reset clears the handshake without a clock edge
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Chunk datapath: one CHUNK-bit adder fed from the latched operands
    always_comb begin
        chunk_lsb = 32'(idx_q) * CHUNK;
        chunk_a   = a_q[chunk_lsb +: CHUNK];
        chunk_b   = b_q[chunk_lsb +: CHUNK];
        {chunk_carry, chunk_sum} = {1'b0, chunk_a} + {1'b0, chunk_b}
                                 + {{CHUNK{1'b0}}, carry_q};
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                sum_d[chunk_lsb +: CHUNK] = chunk_sum;
                carry_d = chunk_carry;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d = chunk_carry;
                    ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder: a 16/4 instance for the main cases and a
// 4/4 instance for the single-chunk configuration.
module tb_serial_chunk_adder;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, cout, ovf;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, sum4;
    logic        cin4, cout4, ovf4;

    int n_checks;
    int n_errors;

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    serial_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full operation on the 16/4 instance; operand pins and in_valid are disturbed
    // while the operation is in flight to show they are ignored.
    task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                          input logic op_cin, input logic [15:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        @(negedge clk);
        check_eq({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = op_a;
        b        = op_b;
        cin      = op_cin;
        @(negedge clk);
        a   = ~op_a;
        b   = op_b ^ 16'h5A5A;
        cin = ~op_cin;
        check_eq({tag, " in_ready run"}, 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        check_eq({tag, " out_valid early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, " sum"}, 32'(sum), 32'(exp_sum));
        check_eq({tag, " cout"}, 32'(cout), 32'(exp_cout));
        check_eq({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check_eq({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        a4         = '0;
        b4         = '0;
        cin4       = 1'b0;

        #12;
        check_eq("rst in_ready", 32'(in_ready), 32'd1);
        check_eq("rst out_valid", 32'(out_valid), 32'd0);
        check_eq("rst sum", 32'(sum), 32'd0);
        check_eq("rst cout", 32'(cout), 32'd0);
        check_eq("rst ovf", 32'(ovf), 32'd0);
        check_eq("rst4 out_valid", 32'(out_valid4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("t1",  16'h0002, 16'h0005, 1'b0, 16'h0007, 1'b0, 1'b0);
        run_op("t2",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("t3",  16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        run_op("neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("mix", 16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0);

        // Stall in DONE with noisy inputs
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h4321;
        cin      = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_eq("t4 out_valid hold", 32'(out_valid), 32'd1);
            check_eq("t4 in_ready hold", 32'(in_ready), 32'd0);
            check_eq("t4 sum hold", 32'(sum), 32'h5555);
            in_valid = ~in_valid;
            a        = a + 16'h0F0F;
            b        = b ^ 16'hFFFF;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("t4 in_ready after", 32'(in_ready), 32'd1);
        check_eq("t4 out_valid after", 32'(out_valid), 32'd0);
        check_eq("t4 sum kept", 32'(sum), 32'h5555);

        // Asynchronous abort during RUN at idx 2
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t5 in_ready run", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5 out_valid rst", 32'(out_valid), 32'd0);
        check_eq("t5 in_ready rst", 32'(in_ready), 32'd1);
        check_eq("t5 sum rst", 32'(sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("t5", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Single-chunk configuration
        @(negedge clk);
        in_valid4 = 1'b1;
        a4        = 4'd10;
        b4        = 4'd5;
        cin4      = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        check_eq("t6 out_valid run", 32'(out_valid4), 32'd0);
        check_eq("t6 in_ready run", 32'(in_ready4), 32'd0);
        @(negedge clk);
        check_eq("t6 out_valid", 32'(out_valid4), 32'd1);
        check_eq("t6 sum", 32'(sum4), 32'd0);
        check_eq("t6 cout", 32'(cout4), 32'd1);
        check_eq("t6 ovf", 32'(ovf4), 32'd0);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        check_eq("t6 in_ready back", 32'(in_ready4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
